quant_sched_ctrl: RTL and testbench

//  Sequencer for the quantizer datapath in the DEM-DAC chain. Paces the modulator at the oversampled tick rate,

---
 rtl/lib_switchblock_pkg.sv | 22 ++
 rtl/quant_tick_gen.sv | 33 +++
 rtl/quant_sched_ctrl.sv | 144 ++++++++++++++
 tb/tb_quant_sched_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lib_switchblock_pkg.sv
`default_nettype none
// ============================================================================
// lib_switchblock_pkg: shared widths, sequencer state type and counter limit.
// Revision 1.0
// ============================================================================
package lib_switchblock_pkg;

  localparam int INPUT_WIDTH  = 16;
  localparam int OUTPUT_WIDTH = 3;

  localparam logic [15:0] CNT16_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    LAUNCH    = 3'd2,
    WAIT_Q    = 3'd3,
    PUSH      = 3'd4
  } quant_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/quant_tick_gen.sv
`default_nettype none
// ============================================================================
// quant_tick_gen: modulo-OSR_DIV tick counter with synchronous clear.
// Revision 1.0
// ============================================================================
module quant_tick_gen #(
  parameter int OSR_DIV = 8,
  parameter int CNT_W   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(OSR_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/quant_sched_ctrl.sv
`default_nettype none
// ============================================================================
// quant_sched_ctrl: tick-paced quantizer sequencer between sample source and DEM.
// Revision 1.0
// ============================================================================
module quant_sched_ctrl #(
  parameter int INPUT_WIDTH  = lib_switchblock_pkg::INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = lib_switchblock_pkg::OUTPUT_WIDTH,
  parameter int OSR_DIV      = 8,
  parameter int QUANT_LAT    = 1,
  parameter int CNT_W        = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [INPUT_WIDTH-1:0]  s_data_i,
  output logic [INPUT_WIDTH-1:0]  q_x_o,
  output logic [INPUT_WIDTH-1:0]  q_ntf_o,
  output logic                    q_start_o,
  input  logic [OUTPUT_WIDTH-1:0] q_out_i,
  input  logic [INPUT_WIDTH-1:0]  q_err_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [OUTPUT_WIDTH-1:0] m_data_o,
  output logic [15:0]             underrun_cnt_o,
  output logic [15:0]             overrun_cnt_o,
  output logic                    busy_o
);

  import lib_switchblock_pkg::*;

  localparam logic [CNT_W-1:0] c_qlast = CNT_W'(QUANT_LAT - 1);

  quant_sched_state_t      r_state;
  logic [INPUT_WIDTH-1:0]  r_sample;
  logic [INPUT_WIDTH-1:0]  r_err;
  logic [INPUT_WIDTH-1:0]  r_qx;
  logic [INPUT_WIDTH-1:0]  r_qntf;
  logic                    r_qstart;
  logic                    r_mvalid;
  logic [OUTPUT_WIDTH-1:0] r_mdata;
  logic [15:0]             r_under;
  logic [15:0]             r_over;
  logic [CNT_W-1:0]        r_qcnt;

  logic                    w_tick;
  logic                    w_tick_clr;
  logic                    w_take;
  logic                    w_qlast;
  logic [INPUT_WIDTH-1:0]  w_sample;

  assign w_tick_clr = (r_state == IDLE) || !en_i;

  quant_tick_gen #(
    .OSR_DIV (OSR_DIV),
    .CNT_W   (CNT_W)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_clr  (w_tick_clr),
    .o_tick (w_tick)
  );

  assign w_take   = (r_state == WAIT_TICK) && en_i && w_tick;
  assign w_qlast  = (r_state == WAIT_Q) && (r_qcnt == c_qlast);
  assign w_sample = s_valid_i ? s_data_i : r_sample;

  // Launch operands are registered on the tick edge so they are stable during the strobe.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= IDLE;
      r_sample <= '0;
      r_err    <= '0;
      r_qx     <= '0;
      r_qntf   <= '0;
      r_qstart <= 1'b0;
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
      r_under  <= '0;
      r_over   <= '0;
      r_qcnt   <= '0;
    end else begin
      r_qstart <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en_i) r_state <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (!en_i) begin
            r_state <= IDLE;
          end else if (w_tick) begin
            r_sample <= w_sample;
            r_qx     <= w_sample;
            r_qntf   <= r_err;
            r_qstart <= 1'b1;
            if (!s_valid_i && (r_under != CNT16_MAX)) r_under <= r_under + 16'd1;
            r_state  <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_qcnt  <= '0;
          r_state <= WAIT_Q;
        end
        WAIT_Q: begin
          if (w_qlast) begin
            r_mdata <= q_out_i;
            r_err   <= q_err_i;
            r_state <= PUSH;
          end else begin
            r_qcnt <= r_qcnt + CNT_W'(1);
          end
        end
        PUSH: begin
          r_state <= en_i ? WAIT_TICK : IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // Valid rises together with the captured code; an unaccepted code being replaced is an overrun.
      if (w_qlast) begin
        r_mvalid <= 1'b1;
      end else if (r_mvalid && m_ready_i) begin
        r_mvalid <= 1'b0;
      end
      if (w_qlast && r_mvalid && !m_ready_i && (r_over != CNT16_MAX)) begin
        r_over <= r_over + 16'd1;
      end
    end
  end

  assign s_ready_o      = w_take;
  assign q_x_o          = r_qx;
  assign q_ntf_o        = r_qntf;
  assign q_start_o      = r_qstart;
  assign m_valid_o      = r_mvalid;
  assign m_data_o       = r_mdata;
  assign underrun_cnt_o = r_under;
  assign overrun_cnt_o  = r_over;
  assign busy_o         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_quant_sched_ctrl.sv
`default_nettype none
// ============================================================================
// tb_quant_sched_ctrl: randomized bench with a cycle-level reference model.
// Revision 1.0
// ============================================================================
module tb_quant_sched_ctrl;

  localparam int OSR_DIV   = 8;
  localparam int QUANT_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        en_i = 1'b0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [15:0] s_data_i = '0;
  logic [15:0] q_x_o;
  logic [15:0] q_ntf_o;
  logic        q_start_o;
  logic [2:0]  q_out_i = '0;
  logic [15:0] q_err_i = '0;
  logic        m_valid_o;
  logic        m_ready_i = 1'b1;
  logic [2:0]  m_data_o;
  logic [15:0] underrun_cnt_o;
  logic [15:0] overrun_cnt_o;
  logic        busy_o;

  quant_sched_ctrl #(
    .INPUT_WIDTH  (16),
    .OUTPUT_WIDTH (3),
    .OSR_DIV      (OSR_DIV),
    .QUANT_LAT    (QUANT_LAT),
    .CNT_W        (8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .s_valid_i      (s_valid_i),
    .s_ready_o      (s_ready_o),
    .s_data_i       (s_data_i),
    .q_x_o          (q_x_o),
    .q_ntf_o        (q_ntf_o),
    .q_start_o      (q_start_o),
    .q_out_i        (q_out_i),
    .q_err_i        (q_err_i),
    .m_valid_o      (m_valid_o),
    .m_ready_i      (m_ready_i),
    .m_data_o       (m_data_o),
    .underrun_cnt_o (underrun_cnt_o),
    .overrun_cnt_o  (overrun_cnt_o),
    .busy_o         (busy_o)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: conversions are tracked by the cycle index of their tick.
  bit          waiting = 1'b0;
  int          conv_t = -1;
  int          run = 0;
  int          mcyc = 0;
  logic [15:0] e_qx = '0, e_qntf = '0, e_under = '0, e_over = '0;
  logic [15:0] m_sample = '0, m_err = '0;
  logic [2:0]  e_mdata = '0;
  bit          e_qstart = 1'b0, e_mvalid = 1'b0;
  bit          was_idle, tick_now;

  task automatic model_reset();
    waiting = 1'b0; conv_t = -1; run = 0;
    e_qx = '0; e_qntf = '0; e_under = '0; e_over = '0;
    m_sample = '0; m_err = '0; e_mdata = '0; e_qstart = 1'b0; e_mvalid = 1'b0;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_i);
    if (!rst_i) begin
      model_reset();
    end else begin
      was_idle = !waiting && (conv_t < 0);
      tick_now = waiting && en_i && (run == OSR_DIV - 1);
      e_qstart = 1'b0;
      if (tick_now) begin
        if (s_valid_i) m_sample = s_data_i;
        else if (e_under != 16'hFFFF) e_under = e_under + 16'd1;
        e_qx = m_sample; e_qntf = m_err; e_qstart = 1'b1;
        conv_t = mcyc; waiting = 1'b0;
      end else if (was_idle && en_i) begin
        waiting = 1'b1;
      end else if (waiting && !en_i) begin
        waiting = 1'b0;
      end
      if (conv_t >= 0 && mcyc == conv_t + 1 + QUANT_LAT) begin
        if (e_mvalid && !m_ready_i && e_over != 16'hFFFF) e_over = e_over + 16'd1;
        e_mdata = q_out_i; m_err = q_err_i; e_mvalid = 1'b1;
      end else if (e_mvalid && m_ready_i) begin
        e_mvalid = 1'b0;
      end
      if (conv_t >= 0 && mcyc == conv_t + QUANT_LAT + 2) begin
        conv_t = -1; waiting = en_i;
      end
      run = (was_idle || !en_i) ? 0 : (run + 1) % OSR_DIV;
      mcyc++;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("s_ready", 32'(s_ready_o), 32'(waiting && en_i && (run == OSR_DIV - 1)));
    chk("busy", 32'(busy_o), 32'(waiting || (conv_t >= 0)));
    chk("q_start", 32'(q_start_o), 32'(e_qstart));
    chk("q_x", 32'(q_x_o), 32'(e_qx));
    chk("q_ntf", 32'(q_ntf_o), 32'(e_qntf));
    chk("m_valid", 32'(m_valid_o), 32'(e_mvalid));
    chk("m_data", 32'(m_data_o), 32'(e_mdata));
    chk("underrun", 32'(underrun_cnt_o), 32'(e_under));
    chk("overrun", 32'(overrun_cnt_o), 32'(e_over));
  end

  // Quantizer stand-in: valid result exactly QUANT_LAT cycles after the strobe, noise otherwise.
  bit          hist [0:QUANT_LAT];
  logic [15:0] lx = '0, ln = '0, qsum;
  logic [2:0]  codes [$];
  logic [15:0] errs [$];

  initial forever begin
    @(negedge clk);
    for (int i = QUANT_LAT; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = q_start_o;
    if (q_start_o) begin lx = q_x_o; ln = q_ntf_o; end
    if (hist[QUANT_LAT]) begin
      qsum    = lx + ln;
      q_out_i = qsum[15:13];
      q_err_i = {3'b000, qsum[12:0]} - 16'h1000;
      codes.push_back(q_out_i);
      errs.push_back(q_err_i);
    end else begin
      q_out_i = 3'($urandom);
      q_err_i = 16'($urandom);
    end
  end

  int          tcyc = 0;
  bit          prev_mv = 1'b0;
  logic [15:0] xs [$];
  logic [15:0] ntfs [$];
  int          scyc [$];
  int          tkc [$];
  int          mvc [$];

  initial forever begin
    @(negedge clk);
    tcyc++;
    if (q_start_o) begin xs.push_back(q_x_o); ntfs.push_back(q_ntf_o); scyc.push_back(tcyc); end
    if (s_ready_o) tkc.push_back(tcyc);
    if (m_valid_o && !prev_mv) mvc.push_back(tcyc);
    prev_mv = m_valid_o;
  end

  bit rnd_ready = 1'b0;

  task automatic feed(input logic v, input logic [15:0] d, output int n);
    n = 0;
    s_valid_i = v;
    s_data_i  = d;
    while (s_ready_o !== 1'b1 && n < 4 * OSR_DIV) begin
      if (rnd_ready) m_ready_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    if (n >= 4 * OSR_DIV) begin
      checks++; errors++;
      $display("FAIL tick_timeout: got no s_ready_o, expected one within %0d cycles", 4 * OSR_DIV);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  int          n;
  int          nst;
  int          nmv;
  logic [2:0]  code_a;

  initial begin
    rst_i = 1'b0; en_i = 1'b1; s_valid_i = 1'b1; s_data_i = 16'h0000; m_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_s_ready", 32'(s_ready_o), 32'd0);
    chk("rst_q_start", 32'(q_start_o), 32'd0);
    chk("rst_m_valid", 32'(m_valid_o), 32'd0);
    rst_i = 1'b1;

    feed(1'b1, 16'h0000, n);
    chk("first_tick_cycle", 32'(n), 32'd8);
    feed(1'b1, 16'h8000, n);
    feed(1'b1, 16'hFFFF, n);
    repeat (QUANT_LAT + 3) @(posedge clk);
    #1;
    chk("stream_x0", 32'(xs[0]), 32'h0000);
    chk("stream_x1", 32'(xs[1]), 32'h8000);
    chk("stream_x2", 32'(xs[2]), 32'hFFFF);
    chk("stream_ntf0", 32'(ntfs[0]), 32'h0000);
    chk("stream_ntf1", 32'(ntfs[1]), 32'(errs[0]));
    chk("stream_ntf2", 32'(ntfs[2]), 32'(errs[1]));
    chk("start_spacing", 32'(scyc[1] - scyc[0]), 32'(OSR_DIV));
    chk("tick_to_valid", 32'(mvc[0] - tkc[0]), 32'(QUANT_LAT + 2));

    repeat (3) feed(1'b0, 16'hDEAD, n);
    repeat (QUANT_LAT + 3) @(posedge clk);
    #1;
    chk("under_x3", 32'(xs[3]), 32'hFFFF);
    chk("under_x4", 32'(xs[4]), 32'hFFFF);
    chk("under_x5", 32'(xs[5]), 32'hFFFF);
    chk("under_cnt", 32'(underrun_cnt_o), 32'd3);

    m_ready_i = 1'b0;
    feed(1'b1, 16'h1234, n);
    repeat (QUANT_LAT + 2) @(posedge clk);
    #1;
    code_a = codes[codes.size() - 1];
    chk("bp_valid_a", 32'(m_valid_o), 32'd1);
    chk("bp_over_0", 32'(overrun_cnt_o), 32'd0);
    feed(1'b1, 16'h4321, n);
    chk("bp_hold_a", 32'(m_data_o), 32'(code_a));
    repeat (QUANT_LAT + 2) @(posedge clk);
    #1;
    chk("bp_over_1", 32'(overrun_cnt_o), 32'd1);
    chk("bp_data_b", 32'(m_data_o), 32'(codes[codes.size() - 1]));
    feed(1'b1, 16'hA5A5, n);
    repeat (QUANT_LAT + 2) @(posedge clk);
    #1;
    chk("bp_over_2", 32'(overrun_cnt_o), 32'd2);
    m_ready_i = 1'b1;

    feed(1'b1, 16'h0F0F, n);
    nmv = mvc.size();
    @(posedge clk);
    #1;
    en_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("enoff_pushed", 32'(mvc.size()), 32'(nmv + 1));
    chk("enoff_busy", 32'(busy_o), 32'd0);
    nst = scyc.size();
    repeat (3 * OSR_DIV) @(posedge clk);
    #1;
    chk("enoff_no_start", 32'(scyc.size()), 32'(nst));

    en_i = 1'b1;
    rnd_ready = 1'b1;
    repeat (40) feed(1'($urandom_range(0, 9) < 7), 16'($urandom), n);
    rnd_ready = 1'b0;
    m_ready_i = 1'b1;
    repeat (OSR_DIV) @(posedge clk);
    #1;

    feed(1'b1, 16'h1357, n);
    @(posedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_m_valid", 32'(m_valid_o), 32'd0);
    chk("arst_q_x", 32'(q_x_o), 32'd0);
    chk("arst_underrun", 32'(underrun_cnt_o), 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    feed(1'b1, 16'h7777, n);
    chk("arst_next_start", 32'(q_start_o), 32'd1);
    chk("arst_next_x", 32'(q_x_o), 32'h7777);
    chk("arst_next_ntf", 32'(q_ntf_o), 32'h0000);
    repeat (QUANT_LAT + 4) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
